// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : elevator_pkg
// Description : Shared definitions for the elevator car-motion controller:
//               FSM state encoding, default timing constants and the width
//               helpers used to size the floor index and the shared timer.
// Revision    : 1.0 - initial release
// ============================================================================
package elevator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DOOR = 2'd2
    } state_t;

    localparam int c_DEFAULT_FLOOR       = 4;
    localparam int c_DEFAULT_MOVE_CYCLES = 200;
    localparam int c_DEFAULT_DOOR_CYCLES = 400;

    // Floor-index width; at least one bit even for a two-floor car.
    function automatic int fw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // The timer is loaded with (cycles - 1), so $clog2 of the larger
    // period is always wide enough.
    function automatic int tw_of(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/elevator_timer.sv
`default_nettype none
// ============================================================================
// Module      : elevator_timer
// Description : Loadable down-counter shared by the MOVE and DOOR phases.
//               Loading value V makes o_done assert V cycles later, so a
//               phase of P cycles is obtained by loading P-1.
// Ports       : clk        - system clock
//               rst        - synchronous active-high reset (count -> 0)
//               i_load     - load i_loadVal this cycle (priority over count)
//               i_loadVal  - value to load
//               o_done     - count has reached zero
// Revision    : 1.0 - initial release
// ============================================================================
module elevator_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_loadVal,
    output logic         o_done
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadVal;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/elevator_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : elevator_ctrl
// Description : Car-motion controller. Latches debounced hall/in-car requests
//               into pending registers and runs a direction-preserving
//               collective policy through IDLE, MOVE and DOOR, with a single
//               shared timer pacing floor travel and door dwell.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               reqUp/reqDown     - hall request bits, bit i = floor i
//               reqInside         - in-car floor request bits
//               curFloor          - current floor index
//               dirUp             - direction preference (1 = up)
//               moving / doorOpen - high in MOVE / DOOR
//               pendUp/pendDown/pendInside - latched requests for the lamps
// Revision    : 1.0 - initial release
// ============================================================================
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int floor       = c_DEFAULT_FLOOR,
    // Derived from floor; leave at its default.
    parameter int FW          = fw_of(floor),
    parameter int MOVE_CYCLES = c_DEFAULT_MOVE_CYCLES,
    parameter int DOOR_CYCLES = c_DEFAULT_DOOR_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [floor-1:0] reqUp,
    input  logic [floor-1:0] reqDown,
    input  logic [floor-1:0] reqInside,
    output logic [FW-1:0]    curFloor,
    output logic             dirUp,
    output logic             moving,
    output logic             doorOpen,
    output logic [floor-1:0] pendUp,
    output logic [floor-1:0] pendDown,
    output logic [floor-1:0] pendInside
);

    localparam int               c_TW        = tw_of(MOVE_CYCLES, DOOR_CYCLES);
    localparam logic [c_TW-1:0]  c_MOVE_LOAD = c_TW'(MOVE_CYCLES - 1);
    localparam logic [c_TW-1:0]  c_DOOR_LOAD = c_TW'(DOOR_CYCLES - 1);
    localparam logic [floor-1:0] c_LSB       = floor'(1);
    // No hall-up button on the top floor, no hall-down on the bottom floor.
    localparam logic [floor-1:0] c_UP_MASK   = ~(c_LSB << (floor - 1));
    localparam logic [floor-1:0] c_DN_MASK   = ~c_LSB;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [FW-1:0]    r_curFloor;
    logic             r_dirUp;
    logic             r_moving;
    logic             r_doorOpen;
    logic [floor-1:0] r_pendUp;
    logic [floor-1:0] r_pendDown;
    logic [floor-1:0] r_pendInside;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t           w_stateNxt;
    logic [FW-1:0]    w_curNxt;
    logic             w_dirNxt;
    logic [floor-1:0] w_clrUp;
    logic [floor-1:0] w_clrDown;
    logic [floor-1:0] w_clrInside;
    logic             w_tmrLoad;
    logic [c_TW-1:0]  w_tmrVal;
    logic             w_tmrDone;

    logic [floor-1:0] w_reqUpM;
    logic [floor-1:0] w_reqDownM;
    logic [floor-1:0] w_upAll;
    logic [floor-1:0] w_dnAll;
    logic [floor-1:0] w_inAll;
    logic [floor-1:0] w_allReq;
    logic [FW-1:0]    w_stepFloor;
    logic [floor-1:0] w_curOh;
    logic [floor-1:0] w_stepOh;
    logic             w_here;
    logic             w_above;
    logic             w_below;
    logic             w_beyond;
    logic             w_stop;
    logic             w_reopen;

    // Live requests are merged with pending ones so that a request arriving
    // on the very edge it is served is cleared before it ever latches.
    assign w_reqUpM   = reqUp & c_UP_MASK;
    assign w_reqDownM = reqDown & c_DN_MASK;
    assign w_upAll    = r_pendUp | w_reqUpM;
    assign w_dnAll    = r_pendDown | w_reqDownM;
    assign w_inAll    = r_pendInside | reqInside;
    assign w_allReq   = w_upAll | w_dnAll | w_inAll;

    // Next floor in the travel direction, saturated at the shaft ends.
    always_comb begin
        w_stepFloor = r_curFloor;
        if (r_dirUp) begin
            if (int'(r_curFloor) != floor - 1) begin
                w_stepFloor = r_curFloor + 1'b1;
            end
        end else begin
            if (r_curFloor != '0) begin
                w_stepFloor = r_curFloor - 1'b1;
            end
        end
    end

    assign w_curOh  = c_LSB << r_curFloor;
    assign w_stepOh = c_LSB << w_stepFloor;
    assign w_here   = |(w_allReq & w_curOh);

    // Masked OR reductions: requests above/below the car, and requests
    // further along the travel direction beyond the floor being reached.
    always_comb begin
        w_above  = 1'b0;
        w_below  = 1'b0;
        w_beyond = 1'b0;
        for (int i = 0; i < floor; i++) begin
            if (i > int'(r_curFloor)) begin
                w_above = w_above | w_allReq[i];
            end
            if (i < int'(r_curFloor)) begin
                w_below = w_below | w_allReq[i];
            end
            if (r_dirUp ? (i > int'(w_stepFloor)) : (i < int'(w_stepFloor))) begin
                w_beyond = w_beyond | w_allReq[i];
            end
        end
    end

    // Stop at the arriving floor for an in-car call, a hall call matching the
    // travel direction, or when nothing remains further on (this also covers
    // the shaft ends, where "further on" is empty).
    assign w_stop = (|(w_inAll & w_stepOh))
                  | (r_dirUp  & (|(w_upAll & w_stepOh)))
                  | (!r_dirUp & (|(w_dnAll & w_stepOh)))
                  | !w_beyond;

    assign w_reopen = (|(w_inAll & w_curOh))
                    | (r_dirUp ? (|(w_upAll & w_curOh)) : (|(w_dnAll & w_curOh)));

    // ------------------------------------------------------------------
    // Shared timer
    // ------------------------------------------------------------------
    elevator_timer #(
        .W (c_TW)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_tmrLoad),
        .i_loadVal (w_tmrVal),
        .o_done    (w_tmrDone)
    );

    // ------------------------------------------------------------------
    // Next-state / control
    // ------------------------------------------------------------------
    always_comb begin
        w_stateNxt  = r_state;
        w_curNxt    = r_curFloor;
        w_dirNxt    = r_dirUp;
        w_clrUp     = '0;
        w_clrDown   = '0;
        w_clrInside = '0;
        w_tmrLoad   = 1'b0;
        w_tmrVal    = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_here) begin
                    w_stateNxt  = ST_DOOR;
                    w_clrUp     = w_curOh;
                    w_clrDown   = w_curOh;
                    w_clrInside = w_curOh;
                    w_tmrLoad   = 1'b1;
                    w_tmrVal    = c_DOOR_LOAD;
                end else if (w_above && (r_dirUp || !w_below)) begin
                    w_stateNxt = ST_MOVE;
                    w_dirNxt   = 1'b1;
                    w_tmrLoad  = 1'b1;
                    w_tmrVal   = c_MOVE_LOAD;
                end else if (w_below) begin
                    w_stateNxt = ST_MOVE;
                    w_dirNxt   = 1'b0;
                    w_tmrLoad  = 1'b1;
                    w_tmrVal   = c_MOVE_LOAD;
                end
            end

            ST_MOVE: begin
                if (w_tmrDone) begin
                    w_curNxt  = w_stepFloor;
                    w_tmrLoad = 1'b1;
                    if (w_stop) begin
                        w_stateNxt  = ST_DOOR;
                        w_tmrVal    = c_DOOR_LOAD;
                        w_clrInside = w_stepOh;
                        if (r_dirUp) begin
                            w_clrUp = w_stepOh;
                        end else begin
                            w_clrDown = w_stepOh;
                        end
                        // Turning around here: the opposite hall call at
                        // this floor is served by the same door cycle.
                        if (!w_beyond) begin
                            w_clrUp   = w_stepOh;
                            w_clrDown = w_stepOh;
                            w_dirNxt  = !r_dirUp;
                        end
                    end else begin
                        w_tmrVal = c_MOVE_LOAD;
                    end
                end
            end

            ST_DOOR: begin
                // Re-open takes priority over the dwell expiring.
                if (w_reopen) begin
                    w_clrInside = w_curOh;
                    if (r_dirUp) begin
                        w_clrUp = w_curOh;
                    end else begin
                        w_clrDown = w_curOh;
                    end
                    w_tmrLoad = 1'b1;
                    w_tmrVal  = c_DOOR_LOAD;
                end else if (w_tmrDone) begin
                    w_stateNxt = ST_IDLE;
                end
            end

            default: begin
                w_stateNxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_curFloor   <= '0;
            r_dirUp      <= 1'b1;
            r_moving     <= 1'b0;
            r_doorOpen   <= 1'b0;
            r_pendUp     <= '0;
            r_pendDown   <= '0;
            r_pendInside <= '0;
        end else begin
            r_state      <= w_stateNxt;
            r_curFloor   <= w_curNxt;
            r_dirUp      <= w_dirNxt;
            r_moving     <= (w_stateNxt == ST_MOVE);
            r_doorOpen   <= (w_stateNxt == ST_DOOR);
            r_pendUp     <= (r_pendUp | w_reqUpM) & ~w_clrUp;
            r_pendDown   <= (r_pendDown | w_reqDownM) & ~w_clrDown;
            r_pendInside <= (r_pendInside | reqInside) & ~w_clrInside;
        end
    end

    assign curFloor   = r_curFloor;
    assign dirUp      = r_dirUp;
    assign moving     = r_moving;
    assign doorOpen   = r_doorOpen;
    assign pendUp     = r_pendUp;
    assign pendDown   = r_pendDown;
    assign pendInside = r_pendInside;

endmodule
`default_nettype wire
